// File: rtl/gst_dma_sound.sv
// DMA sound playback engine: SLOAD_N-fed sample FIFO, rate timebase and
// offset-binary stereo/mono output stage with sticky underrun/overflow flags.
module gst_dma_sound #(
  parameter int unsigned FIFO_ADDR_BITS = 3,
  parameter int unsigned CLK_DIV        = 640,
  parameter int unsigned SAMPLE_BITS    = 8
) (
  input  logic                      i_clk32,
  input  logic                      i_resb,
  input  logic [15:0]               i_mdin,
  input  logic                      i_sload_n,
  output logic                      o_sreq,
  input  logic                      i_cfg_enable,
  input  logic [1:0]                i_cfg_rate,
  input  logic                      i_cfg_mono,
  input  logic                      i_cfg_fmt16,
  input  logic                      i_clr_flags,
  output logic [SAMPLE_BITS-1:0]    o_audio_left,
  output logic [SAMPLE_BITS-1:0]    o_audio_right,
  output logic                      o_sample_stb,
  output logic [FIFO_ADDR_BITS:0]   o_fifo_level,
  output logic                      o_underrun,
  output logic                      o_overflow
);

  localparam int unsigned DEPTH = 2 ** FIFO_ADDR_BITS;
  localparam int unsigned AW    = FIFO_ADDR_BITS;
  localparam int unsigned LW    = FIFO_ADDR_BITS + 1;
  localparam int unsigned CW    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [SAMPLE_BITS-1:0] MID = {1'b1, {(SAMPLE_BITS-1){1'b0}}};

  logic [CW-1:0]          r_base_cnt;
  logic [2:0]             r_rate_cnt;
  logic                   r_sload_q, r_load;
  logic [15:0]            r_mdin;
  logic [15:0]            r_mem [DEPTH];
  logic [AW-1:0]          r_wr_ptr, r_rd_ptr;
  logic [LW-1:0]          r_level;
  logic                   r_phase, r_mono_q, r_fmt_q;
  logic [SAMPLE_BITS-1:0] r_left, r_right;
  logic                   r_stb, r_sreq, r_underrun, r_overflow;

  logic                   w_base_tick, w_rate_ok, w_tick;
  logic                   w_wr, w_ovf, w_need2, w_avail, w_consume, w_urun, w_mode_chg;
  logic [1:0]             w_pop;
  logic [15:0]            w_head, w_next, w_l16, w_r16;
  logic [AW-1:0]          w_rd_nxt;

  // Top SAMPLE_BITS of a signed 16-bit value, converted to offset binary
  function automatic logic [SAMPLE_BITS-1:0] to_out(input logic [15:0] s);
    logic [SAMPLE_BITS-1:0] t;
    t = s[15 -: SAMPLE_BITS];
    t[SAMPLE_BITS-1] = ~t[SAMPLE_BITS-1];
    return t;
  endfunction

  // Timebase: base tick every CLK_DIV cycles, thinned by the rate counter
  always_ff @(posedge i_clk32 or negedge i_resb) begin
    if (!i_resb) begin
      r_base_cnt <= '0;
      r_rate_cnt <= '0;
    end else if (!i_cfg_enable) begin
      r_base_cnt <= '0;
      r_rate_cnt <= '0;
    end else begin
      r_base_cnt <= (r_base_cnt == CW'(CLK_DIV - 1)) ? '0 : r_base_cnt + CW'(1);
      if (w_base_tick) r_rate_cnt <= r_rate_cnt + 3'd1;
    end
  end

  always_comb begin
    w_base_tick = i_cfg_enable & (r_base_cnt == '0);
    w_rate_ok   = 1'b0;
    case (i_cfg_rate)
      2'b11:   w_rate_ok = 1'b1;
      2'b10:   w_rate_ok = ~r_rate_cnt[0];
      2'b01:   w_rate_ok = (r_rate_cnt[1:0] == 2'b00);
      default: w_rate_ok = (r_rate_cnt == 3'b000);
    endcase
    w_tick = w_base_tick & w_rate_ok;
  end

  assign w_rd_nxt = r_rd_ptr + AW'(1);
  assign w_head   = r_mem[r_rd_ptr];
  assign w_next   = r_mem[w_rd_nxt];
  assign w_wr     = r_load & i_cfg_enable & (r_level < LW'(DEPTH));
  assign w_ovf    = r_load & i_cfg_enable & (r_level == LW'(DEPTH));
  assign w_mode_chg = (i_cfg_mono != r_mono_q) | (i_cfg_fmt16 != r_fmt_q);

  // Format decode: words needed, words popped and the two 16-bit sources
  always_comb begin
    w_need2   = i_cfg_fmt16 & ~i_cfg_mono;
    w_avail   = w_need2 ? (r_level >= LW'(2)) : (r_level != '0);
    w_consume = w_tick & w_avail;
    w_urun    = w_tick & ~w_avail;
    w_pop     = 2'd0;
    w_l16     = w_head;
    w_r16     = w_head;
    case ({i_cfg_fmt16, i_cfg_mono})
      2'b00: begin
        w_pop = 2'd1;
        w_l16 = {w_head[15:8], 8'h00};
        w_r16 = {w_head[7:0], 8'h00};
      end
      2'b01: begin
        w_pop = r_phase ? 2'd1 : 2'd0;
        w_l16 = r_phase ? {w_head[7:0], 8'h00} : {w_head[15:8], 8'h00};
        w_r16 = w_l16;
      end
      2'b10: begin
        w_pop = 2'd2;
        w_r16 = w_next;
      end
      default: w_pop = 2'd1;
    endcase
    if (!w_consume) w_pop = 2'd0;
  end

  // Falling-edge detect of SLOAD_N, data captured alongside
  always_ff @(posedge i_clk32 or negedge i_resb) begin
    if (!i_resb) begin
      r_sload_q <= 1'b1;
      r_load    <= 1'b0;
      r_mdin    <= '0;
    end else begin
      r_sload_q <= i_sload_n;
      r_load    <= i_cfg_enable & r_sload_q & ~i_sload_n;
      r_mdin    <= i_mdin;
    end
  end

  always_ff @(posedge i_clk32) begin
    if (w_wr) r_mem[r_wr_ptr] <= r_mdin;
  end

  // FIFO bookkeeping, output stage and request generation
  always_ff @(posedge i_clk32 or negedge i_resb) begin
    if (!i_resb) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
      r_phase  <= 1'b0;
      r_mono_q <= 1'b0;
      r_fmt_q  <= 1'b0;
      r_left   <= MID;
      r_right  <= MID;
      r_stb    <= 1'b0;
      r_sreq   <= 1'b0;
    end else begin
      r_mono_q <= i_cfg_mono;
      r_fmt_q  <= i_cfg_fmt16;
      if (!i_cfg_enable) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_level  <= '0;
        r_phase  <= 1'b0;
        r_left   <= MID;
        r_right  <= MID;
        r_stb    <= 1'b0;
        r_sreq   <= 1'b0;
      end else begin
        if (w_wr) r_wr_ptr <= r_wr_ptr + AW'(1);
        r_rd_ptr <= r_rd_ptr + AW'(w_pop);
        r_level  <= r_level + LW'(w_wr) - LW'(w_pop);
        r_stb    <= w_tick;
        r_sreq   <= (r_level <= LW'(DEPTH - 2));
        if (w_consume) begin
          r_left  <= to_out(w_l16);
          r_right <= to_out(w_r16);
        end
        if (w_mode_chg)
          r_phase <= 1'b0;
        else if (w_consume & i_cfg_mono & ~i_cfg_fmt16)
          r_phase <= ~r_phase;
      end
    end
  end

  // Sticky flags; a same-cycle set wins over clear
  always_ff @(posedge i_clk32 or negedge i_resb) begin
    if (!i_resb) begin
      r_underrun <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_underrun <= w_urun | (r_underrun & ~i_clr_flags);
      r_overflow <= w_ovf  | (r_overflow & ~i_clr_flags);
    end
  end

  assign o_sreq        = r_sreq;
  assign o_audio_left  = r_left;
  assign o_audio_right = r_right;
  assign o_sample_stb  = r_stb;
  assign o_fifo_level  = r_level;
  assign o_underrun    = r_underrun;
  assign o_overflow    = r_overflow;

endmodule

// File: tb/tb_gst_dma_sound.sv
// Directed bench for gst_dma_sound (CLK_DIV=16, 8-deep FIFO, 8-bit output).
module tb_gst_dma_sound;

  logic        clk = 1'b0;
  logic        resb = 1'b0;
  logic [15:0] mdin = '0;
  logic        sload_n = 1'b1;
  logic        sreq;
  logic        en = 1'b0;
  logic [1:0]  rate = 2'b00;
  logic        mono = 1'b0;
  logic        fmt16 = 1'b0;
  logic        clr = 1'b0;
  logic [7:0]  left, right;
  logic        stb;
  logic [3:0]  level;
  logic        urun, ovf;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  gst_dma_sound #(.FIFO_ADDR_BITS(3), .CLK_DIV(16), .SAMPLE_BITS(8)) dut (
    .i_clk32(clk), .i_resb(resb), .i_mdin(mdin), .i_sload_n(sload_n),
    .o_sreq(sreq), .i_cfg_enable(en), .i_cfg_rate(rate), .i_cfg_mono(mono),
    .i_cfg_fmt16(fmt16), .i_clr_flags(clr), .o_audio_left(left),
    .o_audio_right(right), .o_sample_stb(stb), .o_fifo_level(level),
    .o_underrun(urun), .o_overflow(ovf)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic wait_stb(input int max, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      if (stb) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Flush, configure at rate 00, enable and clear the flag from the first empty tick
  task automatic start(input logic f16, input logic m);
    @(posedge clk); #1 en = 1'b0;
    @(posedge clk);
    @(posedge clk); #1 fmt16 = f16; mono = m; rate = 2'b00; en = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1 clr = 1'b1;
    @(posedge clk); #1 clr = 1'b0;
  endtask

  task automatic load_word(input logic [15:0] w);
    @(posedge clk); #1 mdin = w; sload_n = 1'b0;
    @(posedge clk); #1 sload_n = 1'b1;
    @(posedge clk);
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    #12;
    vectors++; if (left !== 8'h80) begin miscompares++; $display("FAIL reset_left: got %h exp 80", left); end
    vectors++; if (right !== 8'h80) begin miscompares++; $display("FAIL reset_right: got %h exp 80", right); end
    vectors++; if ({sreq, stb, urun, ovf} !== 4'b0000) begin miscompares++; $display("FAIL reset_bits: got %b exp 0000", {sreq, stb, urun, ovf}); end
    vectors++; if (level !== 4'd0) begin miscompares++; $display("FAIL reset_level: got %0d exp 0", level); end
    @(posedge clk); #1 resb = 1'b1;
  endtask

  task automatic test_stereo8;
    bit ok;
    start(1'b0, 1'b0);
    @(negedge clk);
    vectors++; if (urun !== 1'b0) begin miscompares++; $display("FAIL st8_clr: got %b exp 0", urun); end
    load_word(16'h7F80);
    @(negedge clk);
    vectors++; if (level !== 4'd1) begin miscompares++; $display("FAIL st8_level_in: got %0d exp 1", level); end
    @(posedge clk); #1 rate = 2'b11;
    wait_stb(40, ok);
    vectors++; if (!ok) begin miscompares++; $display("FAIL st8_stb: got timeout exp strobe"); end
    vectors++; if (left !== 8'hFF) begin miscompares++; $display("FAIL st8_left: got %h exp ff", left); end
    vectors++; if (right !== 8'h00) begin miscompares++; $display("FAIL st8_right: got %h exp 00", right); end
    vectors++; if (level !== 4'd0) begin miscompares++; $display("FAIL st8_level_out: got %0d exp 0", level); end
  endtask

  task automatic test_mono8;
    bit ok;
    start(1'b0, 1'b1);
    load_word(16'h0102);
    @(posedge clk); #1 rate = 2'b11;
    wait_stb(40, ok);
    vectors++; if (!ok || left !== 8'h81 || right !== 8'h81) begin miscompares++; $display("FAIL mono8_first: got %h/%h exp 81/81", left, right); end
    vectors++; if (level !== 4'd1) begin miscompares++; $display("FAIL mono8_nopop: got %0d exp 1", level); end
    // toggling mono back and forth restarts at the high byte
    @(posedge clk); #1 mono = 1'b0;
    @(posedge clk); #1 mono = 1'b1;
    wait_stb(40, ok);
    vectors++; if (!ok || left !== 8'h81 || level !== 4'd1) begin miscompares++; $display("FAIL mono8_phase_reset: got %h lvl %0d exp 81 lvl 1", left, level); end
    wait_stb(40, ok);
    vectors++; if (!ok || left !== 8'h82 || right !== 8'h82) begin miscompares++; $display("FAIL mono8_second: got %h/%h exp 82/82", left, right); end
    vectors++; if (level !== 4'd0 || urun !== 1'b0) begin miscompares++; $display("FAIL mono8_pop: got lvl %0d ur %b exp 0 0", level, urun); end
  endtask

  task automatic test_stereo16;
    bit ok;
    start(1'b1, 1'b0);
    load_word(16'h8000);
    @(posedge clk); #1 rate = 2'b11;
    wait_stb(40, ok);
    vectors++; if (!ok || urun !== 1'b1) begin miscompares++; $display("FAIL st16_underrun: got %b exp 1", urun); end
    vectors++; if (left !== 8'h80 || right !== 8'h80 || level !== 4'd1) begin miscompares++; $display("FAIL st16_hold: got %h/%h lvl %0d exp 80/80 lvl 1", left, right, level); end
    @(posedge clk); #1 clr = 1'b1;
    @(posedge clk); #1 clr = 1'b0;
    @(negedge clk);
    vectors++; if (urun !== 1'b0) begin miscompares++; $display("FAIL st16_clr: got %b exp 0", urun); end
    load_word(16'h7FFF);
    @(negedge clk);
    vectors++; if (level !== 4'd2) begin miscompares++; $display("FAIL st16_level_in: got %0d exp 2", level); end
    wait_stb(40, ok);
    vectors++; if (!ok || left !== 8'h00 || right !== 8'hFF) begin miscompares++; $display("FAIL st16_data: got %h/%h exp 00/ff", left, right); end
    vectors++; if (level !== 4'd0 || urun !== 1'b0) begin miscompares++; $display("FAIL st16_pop2: got lvl %0d ur %b exp 0 0", level, urun); end
  endtask

  task automatic test_mono16;
    bit ok;
    start(1'b1, 1'b1);
    load_word(16'h1234);
    @(posedge clk); #1 rate = 2'b11;
    wait_stb(40, ok);
    vectors++; if (!ok || left !== 8'h92 || right !== 8'h92 || level !== 4'd0) begin miscompares++; $display("FAIL mono16: got %h/%h lvl %0d exp 92/92 lvl 0", left, right, level); end
  endtask

  task automatic test_overflow;
    bit ok;
    logic [7:0] b;
    start(1'b0, 1'b0);
    @(negedge clk);
    vectors++; if (sreq !== 1'b1) begin miscompares++; $display("FAIL ovf_sreq_empty: got %b exp 1", sreq); end
    for (int i = 0; i < 9; i++) begin
      b = i[7:0];
      load_word({b + 8'd1, b + 8'h10});
      @(negedge clk);
      if (i == 5) begin
        vectors++; if (level !== 4'd6 || sreq !== 1'b1) begin miscompares++; $display("FAIL ovf_lvl6: got lvl %0d sreq %b exp 6 1", level, sreq); end
      end
      if (i == 6) begin
        vectors++; if (level !== 4'd7 || sreq !== 1'b0) begin miscompares++; $display("FAIL ovf_lvl7: got lvl %0d sreq %b exp 7 0", level, sreq); end
      end
      if (i == 7) begin
        vectors++; if (level !== 4'd8 || ovf !== 1'b0) begin miscompares++; $display("FAIL ovf_full: got lvl %0d ovf %b exp 8 0", level, ovf); end
      end
      if (i == 8) begin
        vectors++; if (level !== 4'd8 || ovf !== 1'b1) begin miscompares++; $display("FAIL ovf_drop: got lvl %0d ovf %b exp 8 1", level, ovf); end
      end
    end
    @(posedge clk); #1 rate = 2'b11;
    for (int i = 0; i < 8; i++) begin
      b = i[7:0];
      wait_stb(40, ok);
      vectors++;
      if (!ok || left !== ((b + 8'd1) ^ 8'h80) || right !== ((b + 8'h10) ^ 8'h80)) begin
        miscompares++;
        $display("FAIL ovf_drain%0d: got %h/%h exp %h/%h", i, left, right, (b + 8'd1) ^ 8'h80, (b + 8'h10) ^ 8'h80);
      end
    end
    vectors++; if (level !== 4'd0 || urun !== 1'b0) begin miscompares++; $display("FAIL ovf_drained: got lvl %0d ur %b exp 0 0", level, urun); end
    wait_stb(40, ok);
    vectors++; if (!ok || urun !== 1'b1) begin miscompares++; $display("FAIL ovf_ninth_dropped: got ur %b exp 1", urun); end
  endtask

  task automatic test_rates;
    bit ok;
    int t0, t1;
    start(1'b0, 1'b0);
    wait_stb(200, ok); t0 = cyc;
    wait_stb(200, ok); t1 = cyc;
    vectors++; if (!ok || (t1 - t0) !== 128) begin miscompares++; $display("FAIL rate00_period: got %0d exp 128", t1 - t0); end
    @(negedge clk);
    vectors++; if (stb !== 1'b0) begin miscompares++; $display("FAIL stb_width: got %b exp 0", stb); end
    @(posedge clk); #1 rate = 2'b10;
    wait_stb(200, ok); t0 = cyc;
    wait_stb(200, ok); t1 = cyc;
    vectors++; if (!ok || (t1 - t0) !== 32) begin miscompares++; $display("FAIL rate10_period: got %0d exp 32", t1 - t0); end
  endtask

  task automatic test_disable_reset;
    bit ok;
    start(1'b0, 1'b0);
    load_word(16'h7F80);
    load_word(16'h1111);
    @(posedge clk); #1 rate = 2'b11;
    wait_stb(40, ok);
    vectors++; if (!ok || left !== 8'hFF || level !== 4'd1) begin miscompares++; $display("FAIL dis_pre: got %h lvl %0d exp ff lvl 1", left, level); end
    @(posedge clk); #1 en = 1'b0;
    @(posedge clk);
    @(negedge clk);
    vectors++; if (level !== 4'd0 || sreq !== 1'b0) begin miscompares++; $display("FAIL dis_flush: got lvl %0d sreq %b exp 0 0", level, sreq); end
    vectors++; if (left !== 8'h80 || right !== 8'h80) begin miscompares++; $display("FAIL dis_mid: got %h/%h exp 80/80", left, right); end
    @(posedge clk); #1 en = 1'b1;
    @(posedge clk);
    @(negedge clk);
    vectors++; if (urun !== 1'b1) begin miscompares++; $display("FAIL rst_pre_urun: got %b exp 1", urun); end
    @(posedge clk); #1 mdin = 16'hABCD; sload_n = 1'b0;
    #2 resb = 1'b0;
    #1;
    vectors++; if ({sreq, stb, urun, ovf} !== 4'b0000 || level !== 4'd0) begin miscompares++; $display("FAIL rst_mid: got %b lvl %0d exp 0000 lvl 0", {sreq, stb, urun, ovf}, level); end
    vectors++; if (left !== 8'h80 || right !== 8'h80) begin miscompares++; $display("FAIL rst_mid_audio: got %h/%h exp 80/80", left, right); end
    sload_n = 1'b1;
    @(posedge clk); #1 resb = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    vectors++; if (level !== 4'd0) begin miscompares++; $display("FAIL rst_load_lost: got %0d exp 0", level); end
  endtask

  initial begin
    test_reset();
    test_stereo8();
    test_mono8();
    test_stereo16();
    test_mono16();
    test_overflow();
    test_rates();
    test_disable_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
